// File: rtl/alu.sv
// Phaethon multi-cycle 32-bit core: fetches 4-byte little-endian
// instructions from a 256-byte RAM over a req/ack handshake and executes them.
// Optional build macro ALU_MUL_EN adds opcode 0x0C (MUL); without it 0x0C is a NOP.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ramValue,
  input  logic        readAck,
  input  logic        writeAck,
  output logic [7:0]  ramAddress,
  output logic [31:0] ramOut,
  output logic        readReq,
  output logic        writeReq,
  output logic [7:0]  iPointer,
  output logic [7:0]  opCode,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] debug
);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_IMM, S_LOAD, S_STORE, S_HALT
  } state_t;

  state_t      state;
  logic [7:0]  ip;
  logic [31:0] regs [4];
  logic [31:0] dbg;
  logic [1:0]  d_sel;
  logic [7:0]  s_byte;
  logic [7:0]  imm8;
  logic [31:0] mem_data;
  logic        seen_low;

  logic        busy;
  logic        ack;
  logic        done;
  logic [31:0] rd;
  logic [31:0] rs;
  logic        wr_en;
  logic [31:0] wr_val;
  logic [7:0]  ip_next;
  logic        unused_bits;

  assign busy = readReq | writeReq;
  assign ack  = readReq ? readAck : writeAck;
  // An ack only completes a transfer once a low ack has been seen in this
  // request, so a stale high left from the previous transfer is ignored.
  assign done = busy & ack & seen_low;
  assign rd   = regs[d_sel];
  assign rs   = regs[s_byte[1:0]];
  assign unused_bits = ^ramValue[15:10];

  assign iPointer = ip;
  assign r0       = regs[0];
  assign r1       = regs[1];
  assign debug    = dbg;

  // Execute-stage result and next instruction pointer for the latched opcode.
  always_comb begin
    wr_en   = 1'b0;
    wr_val  = rd;
    ip_next = ip + 8'd4;
    case (opCode)
      8'h01: begin wr_en = 1'b1; wr_val = {24'b0, imm8}; end
      8'h02: begin wr_en = 1'b1; wr_val = mem_data; ip_next = ip + 8'd8; end
      8'h03: begin wr_en = 1'b1; wr_val = rs; end
      8'h04: begin wr_en = 1'b1; wr_val = rd + rs; end
      8'h05: begin wr_en = 1'b1; wr_val = rd - rs; end
      8'h06: begin wr_en = 1'b1; wr_val = rd & rs; end
      8'h07: begin wr_en = 1'b1; wr_val = rd | rs; end
      8'h08: begin wr_en = 1'b1; wr_val = rd ^ rs; end
      8'h09: begin wr_en = 1'b1; wr_val = rd + {24'b0, imm8}; end
      8'h0A: begin wr_en = 1'b1; wr_val = rd << imm8[4:0]; end
      8'h0B: begin wr_en = 1'b1; wr_val = rd >> imm8[4:0]; end
`ifdef ALU_MUL_EN
      8'h0C: begin wr_en = 1'b1; wr_val = rd * rs; end
`endif
      8'h10: begin wr_en = 1'b1; wr_val = mem_data; end
      8'h20: ip_next = s_byte;
      8'h21: if (rd == 32'd0) ip_next = s_byte;
      default: ;
    endcase
  end

  // Sequencer: bus transfers, instruction latch and architectural updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      ip         <= 8'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
      dbg        <= 32'd0;
      opCode     <= 8'd0;
      d_sel      <= 2'd0;
      s_byte     <= 8'd0;
      imm8       <= 8'd0;
      mem_data   <= 32'd0;
      seen_low   <= 1'b0;
      ramAddress <= 8'd0;
      ramOut     <= 32'd0;
      readReq    <= 1'b0;
      writeReq   <= 1'b0;
    end else begin
      if (busy && !ack) seen_low <= 1'b1;
      case (state)
        S_FETCH: begin
          if (!busy) begin
            readReq    <= 1'b1;
            ramAddress <= ip;
            seen_low   <= 1'b0;
          end else if (done) begin
            readReq <= 1'b0;
            opCode  <= ramValue[7:0];
            d_sel   <= ramValue[9:8];
            s_byte  <= ramValue[23:16];
            imm8    <= ramValue[31:24];
            case (ramValue[7:0])
              8'h02:   state <= S_IMM;
              8'h10:   state <= S_LOAD;
              8'h11:   state <= S_STORE;
              default: state <= S_EXEC;
            endcase
          end
        end
        S_IMM: begin
          if (!busy) begin
            readReq    <= 1'b1;
            ramAddress <= ip + 8'd4;
            seen_low   <= 1'b0;
          end else if (done) begin
            readReq  <= 1'b0;
            mem_data <= ramValue;
            state    <= S_EXEC;
          end
        end
        S_LOAD: begin
          if (!busy) begin
            readReq    <= 1'b1;
            ramAddress <= s_byte;
            seen_low   <= 1'b0;
          end else if (done) begin
            readReq  <= 1'b0;
            mem_data <= ramValue;
            state    <= S_EXEC;
          end
        end
        S_STORE: begin
          if (!busy) begin
            writeReq   <= 1'b1;
            ramAddress <= s_byte;
            ramOut     <= rd;
            seen_low   <= 1'b0;
          end else if (done) begin
            writeReq <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (opCode == 8'hFF) begin
            state <= S_HALT;
          end else begin
            if (wr_en) regs[d_sel] <= wr_val;
            if (opCode == 8'h30) dbg <= rd;
            ip    <= ip_next;
            state <= S_FETCH;
          end
        end
        S_HALT:  ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for the Phaethon core: a RAM responder with random ack latency,
// a queue of expected bus transfers, and directed programs.
module tb_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;
  logic [7:0]  ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [7:0]  iPointer;
  logic [7:0]  opCode;
  logic [31:0] r0;
  logic [31:0] r1;
  logic [31:0] debug;

  logic [7:0]  mem [256];
  int          total = 0;
  int          bad = 0;
  int          extra_cnt = 0;
  bit          manual = 1'b0;
  bit          strict = 1'b1;
  logic        resp_rack = 1'b0;
  logic        resp_wack = 1'b0;
  logic [31:0] resp_val = 32'd0;
  logic        man_ack = 1'b0;
  logic [31:0] man_val = 32'd0;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [31:0] data;
  } xact_t;
  xact_t sb [$];

  assign readAck  = manual ? man_ack : resp_rack;
  assign ramValue = manual ? man_val : resp_val;
  assign writeAck = manual ? 1'b0 : resp_wack;

  alu dut (
    .clk(clk), .reset(reset), .ramValue(ramValue), .readAck(readAck),
    .writeAck(writeAck), .ramAddress(ramAddress), .ramOut(ramOut),
    .readReq(readReq), .writeReq(writeReq), .iPointer(iPointer),
    .opCode(opCode), .r0(r0), .r1(r1), .debug(debug)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM responder: acks after a random delay, always low for at least one sample.
  initial begin : responder
    int    cnt;
    int    dly;
    xact_t x;
    cnt = 0;
    dly = 1;
    forever begin
      @(negedge clk);
      if (manual || reset || !(readReq || writeReq)) begin
        resp_rack = 1'b0;
        resp_wack = 1'b0;
        cnt = 0;
      end else if (!(resp_rack || resp_wack)) begin
        if (cnt == 0) dly = $urandom_range(1, 3);
        cnt++;
        if (cnt > dly) begin
          check("req_exclusive", 32'(readReq & writeReq), 32'd0);
          if (writeReq) begin
            mem[ramAddress]         = ramOut[7:0];
            mem[ramAddress + 8'd1]  = ramOut[15:8];
            mem[ramAddress + 8'd2]  = ramOut[23:16];
            mem[ramAddress + 8'd3]  = ramOut[31:24];
            resp_wack = 1'b1;
          end else begin
            resp_val = {mem[ramAddress + 8'd3], mem[ramAddress + 8'd2],
                        mem[ramAddress + 8'd1], mem[ramAddress]};
            resp_rack = 1'b1;
          end
          if (sb.size() > 0) begin
            x = sb.pop_front();
            check("xfer_kind", 32'(writeReq), 32'(x.wr));
            check("xfer_addr", 32'(ramAddress), 32'(x.addr));
            if (x.wr) check("xfer_data", ramOut, x.data);
          end else if (strict) begin
            extra_cnt++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_prog(bit is_strict);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    sb.delete();
    extra_cnt = 0;
    strict = is_strict;
    cycles(2);
  endtask

  task automatic wr_word(logic [7:0] a, logic [31:0] w);
    mem[a]        = w[7:0];
    mem[a + 8'd1] = w[15:8];
    mem[a + 8'd2] = w[23:16];
    mem[a + 8'd3] = w[31:24];
  endtask

  task automatic exp_rd(logic [7:0] a);
    xact_t x;
    x.wr = 1'b0; x.addr = a; x.data = 32'd0;
    sb.push_back(x);
  endtask

  task automatic exp_wr(logic [7:0] a, logic [31:0] d);
    xact_t x;
    x.wr = 1'b1; x.addr = a; x.data = d;
    sb.push_back(x);
  endtask

  task automatic run_to_halt(string tag);
    int n = 0;
    while (opCode !== 8'hFF && n < 3000) begin
      cycles(1);
      n++;
    end
    check({tag, "_halt"}, 32'(opCode), 32'h0000_00FF);
    cycles(20);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_no_extra"}, 32'(extra_cnt), 32'd0);
  endtask

  task automatic run_to_drain(string tag);
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin
      cycles(1);
      n++;
    end
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin : main
    // Reset state, then NOPs from zeroed memory.
    start_prog(1'b0);
    check("rst_ip", 32'(iPointer), 32'd0);
    check("rst_rreq", 32'(readReq), 32'd0);
    check("rst_wreq", 32'(writeReq), 32'd0);
    check("rst_opcode", 32'(opCode), 32'd0);
    check("rst_r0", r0, 32'd0);
    check("rst_debug", debug, 32'd0);
    for (int i = 0; i < 6; i++) exp_rd(8'(i * 4));
    reset = 1'b0;
    run_to_drain("nop");

    // MOVI/MOVI/ADD/OUT.
    start_prog(1'b1);
    wr_word(8'h00, 32'h0500_0001);
    wr_word(8'h04, 32'h0700_0101);
    wr_word(8'h08, 32'h0001_0004);
    wr_word(8'h0C, 32'h0000_0030);
    wr_word(8'h10, 32'h0000_00FF);
    for (int i = 0; i < 5; i++) exp_rd(8'(i * 4));
    reset = 1'b0;
    run_to_halt("add");
    check("add_r0", r0, 32'h0000_000C);
    check("add_r1", r1, 32'h0000_0007);
    check("add_debug", debug, 32'h0000_000C);
    check("add_ip", 32'(iPointer), 32'h10);

    // MOVW then ADDI with wrap-around.
    start_prog(1'b1);
    wr_word(8'h00, 32'h0000_0102);
    wr_word(8'h04, 32'hFFFF_FFFF);
    wr_word(8'h08, 32'h0200_0109);
    wr_word(8'h0C, 32'h0000_00FF);
    exp_rd(8'h00); exp_rd(8'h04); exp_rd(8'h08); exp_rd(8'h0C);
    reset = 1'b0;
    run_to_halt("movw");
    check("movw_r1", r1, 32'h0000_0001);
    check("movw_ip", 32'(iPointer), 32'h0C);

    // STORE then LOAD through RAM.
    start_prog(1'b1);
    wr_word(8'h00, 32'h0000_0002);
    wr_word(8'h04, 32'h1234_5678);
    wr_word(8'h08, 32'h0040_0011);
    wr_word(8'h0C, 32'h0040_0110);
    wr_word(8'h10, 32'h0000_00FF);
    exp_rd(8'h00); exp_rd(8'h04); exp_rd(8'h08); exp_wr(8'h40, 32'h1234_5678);
    exp_rd(8'h0C); exp_rd(8'h40); exp_rd(8'h10);
    reset = 1'b0;
    run_to_halt("ldst");
    check("ldst_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h7856_3412);
    check("ldst_r1", r1, 32'h1234_5678);
    check("ldst_r0", r0, 32'h1234_5678);

    // Logic, subtract, shifts, MOV, 0x0C and an undefined opcode.
    start_prog(1'b1);
    wr_word(8'h00, 32'hF000_0001);
    wr_word(8'h04, 32'h3C00_0101);
    wr_word(8'h08, 32'h0000_0203);
    wr_word(8'h0C, 32'h0001_0206);
    wr_word(8'h10, 32'h0000_0230);
    wr_word(8'h14, 32'h0000_0303);
    wr_word(8'h18, 32'h0001_0307);
    wr_word(8'h1C, 32'h0001_0008);
    wr_word(8'h20, 32'h0000_0105);
    wr_word(8'h24, 32'h0400_000A);
    wr_word(8'h28, 32'h1C00_010B);
    wr_word(8'h2C, 32'h0000_0330);
    wr_word(8'h30, 32'h0001_000C);
    wr_word(8'h34, 32'h0000_000D);
    wr_word(8'h38, 32'h0000_00FF);
    for (int i = 0; i < 15; i++) exp_rd(8'(i * 4));
    reset = 1'b0;
    cycles(1);
    while (opCode !== 8'h30 && sb.size() > 10) cycles(1);
    cycles(12);
    check("alu_debug_and", debug, 32'h0000_0030);
    run_to_halt("alu");
`ifdef ALU_MUL_EN
    check("alu_r0", r0, 32'h0000_BF40);
`else
    check("alu_r0", r0, 32'h0000_0CC0);
`endif
    check("alu_r1", r1, 32'h0000_000F);
    check("alu_debug", debug, 32'h0000_00FC);

    // JZ not taken, JZ taken, HALT with no further requests.
    start_prog(1'b1);
    wr_word(8'h00, 32'h0100_0101);
    wr_word(8'h04, 32'h0040_0121);
    wr_word(8'h08, 32'h0010_0021);
    wr_word(8'h10, 32'h0000_00FF);
    exp_rd(8'h00); exp_rd(8'h04); exp_rd(8'h08); exp_rd(8'h10);
    reset = 1'b0;
    run_to_halt("jz");
    check("jz_ip", 32'(iPointer), 32'h10);
    check("jz_rreq", 32'(readReq), 32'd0);

    // JMP to 0xFC then NOP: ip wraps to 0.
    start_prog(1'b0);
    wr_word(8'h00, 32'h00FC_0020);
    exp_rd(8'h00); exp_rd(8'hFC); exp_rd(8'h00); exp_rd(8'hFC);
    reset = 1'b0;
    run_to_drain("jmp");

    // Stale ack handling and reset during a fetch wait.
    start_prog(1'b0);
    manual = 1'b1;
    man_ack = 1'b1;
    man_val = 32'd0;
    reset = 1'b0;
    cycles(4);
    check("stale_rreq_held", 32'(readReq), 32'd1);
    check("stale_opcode", 32'(opCode), 32'd0);
    man_ack = 1'b0;
    cycles(1);
    man_ack = 1'b1;
    man_val = 32'h0500_0001;
    cycles(1);
    check("stale_done_rreq", 32'(readReq), 32'd0);
    check("stale_done_opcode", 32'(opCode), 32'h01);
    cycles(2);
    check("stale_next_rreq", 32'(readReq), 32'd1);
    check("stale_next_addr", 32'(ramAddress), 32'h04);
    check("stale_r0", r0, 32'h5);
    cycles(2);
    check("stale_carry_ignored", 32'(readReq), 32'd1);
    reset = 1'b1;
    man_ack = 1'b0;
    cycles(1);
    check("midrst_rreq", 32'(readReq), 32'd0);
    check("midrst_ip", 32'(iPointer), 32'd0);
    check("midrst_r0", r0, 32'd0);
    manual = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
